pmod_button_counter: RTL and testbench

Input-side companion to the LED clock-divider counter: it takes the two raw PMOD push-buttons, synchronises and debounces them, and turns each clean press into a single count event. pmod[0] increments and pmod[1] decrements a wrap-around value that drives the LEDs directly. It sits between the PMOD header pins and the LED bank on the 12 MHz board clock.

---
 rtl/pmod_button_counter.sv | 176 +++++++++++++++++
 tb/tb_pmod_button_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_button_counter.sv
// pmod_button_counter
//   Two raw PMOD push-buttons are synchronised, debounced and edge-detected.
//   pmod[0] steps the LED count up, pmod[1] steps it down; both wrap modulo
//   2^LED_WIDTH. An up and a down event on the same cycle cancel.
//
//   Optional feature: define AUTO_REPEAT_EN to build per-button hold counters
//   that emit extra events while a button stays pressed. The first repeat
//   comes HOLD_CYCLES after the press event, then one every REPEAT_CYCLES.
//   Without the macro every debounced press produces exactly one event.
module pmod_button_counter #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd120000,
    parameter int          LED_WIDTH       = 4,
    parameter logic [23:0] HOLD_CYCLES     = 24'd6000000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd1200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           pmod,
    output logic [LED_WIDTH-1:0] led,
    output logic                 step
);

    // Per-channel count events: bit 0 = up, bit 1 = down.
    logic [1:0] ev;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_chan
            // Synchroniser: sync_q[0] is the metastability catcher,
            // sync_q[1] is the clean synchronised level.
            logic [1:0]  sync_q;
            logic [1:0]  sync_d;
            // Debouncer state: accepted level plus run length of disagreement.
            logic        stable_q;
            logic        stable_d;
            logic [23:0] mis_q;
            logic [23:0] mis_d;
            // Previous accepted level, for the rising-edge detector.
            logic        prev_q;
            logic        prev_d;
            logic        press_ev;
            logic        rpt_fire;

            // Shift the raw pin into the two-flop synchroniser.
            always_comb begin
                sync_d = {sync_q[0], pmod[gi]};
            end

            // Accept a level change only after DEBOUNCE_CYCLES consecutive
            // disagreeing samples; any agreement restarts the count.
            always_comb begin
                stable_d = stable_q;
                mis_d    = '0;
                if (sync_q[1] != stable_q) begin
                    if (mis_q == DEBOUNCE_CYCLES - 24'd1) begin
                        stable_d = ~stable_q;
                        mis_d    = '0;
                    end else begin
                        mis_d = mis_q + 24'd1;
                    end
                end
            end

            // Remember the last accepted level so presses fire exactly once.
            always_comb begin
                prev_d   = stable_q;
                press_ev = stable_q & ~prev_q;
            end

`ifdef AUTO_REPEAT_EN
            // Hold counter: counts cycles since the press (phase 0) or since
            // the last repeat (phase 1). Cleared whenever the button is up.
            logic [23:0] hold_q;
            logic [23:0] hold_d;
            logic        phase_q;
            logic        phase_d;

            // Decide when a held button emits another event. Gating with
            // stable_q stops repeats as soon as the release is accepted.
            always_comb begin
                hold_d   = '0;
                phase_d  = 1'b0;
                rpt_fire = 1'b0;
                if (stable_q) begin
                    hold_d  = hold_q + 24'd1;
                    phase_d = phase_q;
                    if (!phase_q && (hold_q == HOLD_CYCLES)) begin
                        rpt_fire = 1'b1;
                        hold_d   = 24'd1;
                        phase_d  = 1'b1;
                    end else if (phase_q && (hold_q == REPEAT_CYCLES)) begin
                        rpt_fire = 1'b1;
                        hold_d   = 24'd1;
                    end
                end
            end

            // Hold counter registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q  <= '0;
                    phase_q <= 1'b0;
                end else begin
                    hold_q  <= hold_d;
                    phase_q <= phase_d;
                end
            end
`else
            assign rpt_fire = 1'b0;
`endif

            assign ev[gi] = press_ev | rpt_fire;

            // Synchroniser, debouncer and edge-detector registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q   <= '0;
                    stable_q <= 1'b0;
                    mis_q    <= '0;
                    prev_q   <= 1'b0;
                end else begin
                    sync_q   <= sync_d;
                    stable_q <= stable_d;
                    mis_q    <= mis_d;
                    prev_q   <= prev_d;
                end
            end
        end
    endgenerate

`ifndef AUTO_REPEAT_EN
    // Repeat timing parameters have no hardware in this build.
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

    logic [LED_WIDTH-1:0] led_q;
    logic [LED_WIDTH-1:0] led_d;
    logic                 step_q;
    logic                 step_d;

    // Apply a lone up or down event; simultaneous events cancel out.
    always_comb begin
        led_d  = led_q;
        step_d = 1'b0;
        case (ev)
            2'b01: begin
                led_d  = led_q + LED_WIDTH'(1);
                step_d = 1'b1;
            end
            2'b10: begin
                led_d  = led_q - LED_WIDTH'(1);
                step_d = 1'b1;
            end
            default: begin
                led_d  = led_q;
                step_d = 1'b0;
            end
        endcase
    end

    // Counter and step registers; outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q  <= '0;
            step_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_pmod_button_counter.sv
// Directed testbench for pmod_button_counter with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=3, LED_WIDTH=4. Define AUTO_REPEAT_EN to
// check the repeat build; expectations adapt to the macro.
module tb_pmod_button_counter;

`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] pmod;
    logic [3:0] led;
    logic       step;

    int checks;
    int errors;

    pmod_button_counter #(
        .DEBOUNCE_CYCLES(24'd4),
        .LED_WIDTH      (4),
        .HOLD_CYCLES    (24'd10),
        .REPEAT_CYCLES  (24'd3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pmod(pmod),
        .led (led),
        .step(step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: put the DUT back into its reset state with buttons up.
    task automatic apply_reset();
        rst  = 1'b1;
        pmod = 2'b00;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Reset with both buttons held, then release reset while still held.
    task automatic test_reset();
        rst  = 1'b1;
        pmod = 2'b11;
        for (int t = 1; t <= 3; t++) begin
            tick();
            checks++;
            if (led !== 4'd0 || step !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold t=%0d led=%0d step=%0b want led=0 step=0", t, led, step);
            end
        end
        rst = 1'b0;
        for (int t = 1; t <= 27; t++) begin
            if (t == 16) pmod = 2'b00;
            tick();
            checks++;
            if (led !== 4'd0 || step !== 1'b0) begin
                errors++;
                $display("FAIL reset_release t=%0d led=%0d step=%0b want led=0 step=0", t, led, step);
            end
        end
        $display("test_reset done: led=%0d", led);
    endtask

    // One 20-cycle press of the up button.
    task automatic test_single_press();
        logic [3:0] exp_led;
        logic       exp_step;
        apply_reset();
        exp_led = 4'd0;
        for (int t = 1; t <= 32; t++) begin
            pmod = (t <= 20) ? 2'b01 : 2'b00;
            tick();
            exp_step = (t == 7) || (AR && t >= 17 && t <= 26 && ((t - 17) % 3 == 0));
            if (exp_step) exp_led = exp_led + 4'd1;
            checks++;
            if (led !== exp_led || step !== exp_step) begin
                errors++;
                $display("FAIL single_press t=%0d led=%0d step=%0b want led=%0d step=%0b",
                         t, led, step, exp_led, exp_step);
            end
        end
        $display("test_single_press done: led=%0d", led);
    endtask

    // Pulses of 1, 2 and 3 cycles must all be filtered out.
    task automatic test_glitch();
        apply_reset();
        for (int len = 1; len <= 3; len++) begin
            for (int t = 1; t <= len + 5; t++) begin
                pmod = (t <= len) ? 2'b01 : 2'b00;
                tick();
                checks++;
                if (led !== 4'd0 || step !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch len=%0d t=%0d led=%0d step=%0b want led=0 step=0",
                             len, t, led, step);
                end
            end
        end
        repeat (8) tick();
        checks++;
        if (led !== 4'd0) begin
            errors++;
            $display("FAIL glitch_tail led=%0d want 0", led);
        end
        $display("test_glitch done: led=%0d", led);
    endtask

    // Sixteen up presses wrap 15 -> 0, then one down press wraps 0 -> 15.
    task automatic test_wrap();
        logic [3:0] exp_led;
        int         steps;
        apply_reset();
        exp_led = 4'd0;
        for (int i = 1; i <= 17; i++) begin
            steps = 0;
            pmod  = (i <= 16) ? 2'b01 : 2'b10;
            repeat (5) begin
                tick();
                if (step === 1'b1) steps++;
            end
            pmod = 2'b00;
            repeat (10) begin
                tick();
                if (step === 1'b1) steps++;
            end
            exp_led = (i <= 16) ? exp_led + 4'd1 : exp_led - 4'd1;
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL wrap_led press=%0d led=%0d want %0d", i, led, exp_led);
            end
            checks++;
            if (steps != 1) begin
                errors++;
                $display("FAIL wrap_steps press=%0d steps=%0d want 1", i, steps);
            end
            $display("wrap press %0d: led=%0d steps=%0d", i, led, steps);
        end
    endtask

    // Same-cycle presses cancel; presses two cycles apart both apply.
    task automatic test_simultaneous();
        logic [3:0] exp_led;
        logic       exp_step;
        apply_reset();
        for (int t = 1; t <= 22; t++) begin
            pmod = (t <= 8) ? 2'b11 : 2'b00;
            tick();
            checks++;
            if (led !== 4'd0 || step !== 1'b0) begin
                errors++;
                $display("FAIL simul_same t=%0d led=%0d step=%0b want led=0 step=0", t, led, step);
            end
        end
        for (int t = 1; t <= 25; t++) begin
            pmod[0] = (t <= 8);
            pmod[1] = (t >= 3 && t <= 10);
            tick();
            exp_led  = (t == 7 || t == 8) ? 4'd1 : 4'd0;
            exp_step = (t == 7 || t == 9);
            checks++;
            if (led !== exp_led || step !== exp_step) begin
                errors++;
                $display("FAIL simul_offset t=%0d led=%0d step=%0b want led=%0d step=%0b",
                         t, led, step, exp_led, exp_step);
            end
        end
        $display("test_simultaneous done: led=%0d", led);
    endtask

    // 40-cycle hold: repeats when the macro is defined, one event otherwise.
    task automatic test_back_to_back_hold();
        logic [3:0] exp_led;
        logic       exp_step;
        apply_reset();
        exp_led = 4'd0;
        for (int t = 1; t <= 55; t++) begin
            pmod = (t <= 40) ? 2'b01 : 2'b00;
            tick();
            exp_step = (t == 7) || (AR && t >= 17 && t <= 46 && ((t - 17) % 3 == 0));
            if (exp_step) exp_led = exp_led + 4'd1;
            checks++;
            if (led !== exp_led || step !== exp_step) begin
                errors++;
                $display("FAIL hold40 t=%0d led=%0d step=%0b want led=%0d step=%0b",
                         t, led, step, exp_led, exp_step);
            end
        end
        $display("test_back_to_back_hold done: led=%0d", led);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        pmod   = 2'b11;
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap();
        test_simultaneous();
        test_back_to_back_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
